// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths and types for the write-back port arbiter.
// FIFO entries are {rd, data}; the grant encoding names the RF write-port owner.
package wb_port_arbiter_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned XLEN  = 32;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  data;
    } wba_entry_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_W,
        GNT_FIFO,
        GNT_BYP
    } wba_grant_e;

endpackage

// File: rtl/wba_result_fifo.sv
// Synchronous result FIFO for long-latency results.
// It uses wrap-bit pointers and accepts a push while full if a pop happens in the same cycle.
module wba_result_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  wba_entry_t             din_i,
    output wba_entry_t             dout_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    wba_entry_t  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        full, do_push, do_pop;

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full | do_pop);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the RF write port between write-back and the long-latency unit, with busy scoreboard.
// Optional WBA_BYPASS_EN: a result writes the RF directly when the port and FIFO are idle.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned MAX_OUT    = 4,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_valid,
    input  logic             w_wen,
    input  logic [REG_W-1:0] w_rd,
    input  logic [XLEN-1:0]  w_wdata,
    input  logic             lu_issue_valid,
    input  logic [REG_W-1:0] lu_issue_rd,
    output logic             lu_issue_ready,
    input  logic             lu_res_valid,
    input  logic [REG_W-1:0] lu_res_rd,
    input  logic [XLEN-1:0]  lu_res_data,
    output logic             lu_res_ready,
    input  logic [REG_W-1:0] d_rs1,
    input  logic [REG_W-1:0] d_rs2,
    input  logic [REG_W-1:0] d_rd,
    input  logic             d_use1,
    input  logic             d_use2,
    input  logic             d_wen,
    output logic             d_sb_stall,
    output logic             pipe_hold,
    output logic             rf_we,
    output logic [REG_W-1:0] rf_waddr,
    output logic [XLEN-1:0]  rf_wdata
);
    localparam int unsigned      OUT_W      = $clog2(MAX_OUT + 1);
    localparam int unsigned      CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned      STV_W      = $clog2(STARVE_MAX + 1);
    localparam logic [STV_W-1:0] STARVE_LIM = STV_W'(STARVE_MAX - 1);

    logic [(1<<REG_W)-1:0] busy_q, busy_d;
    logic [OUT_W-1:0]      out_q, out_d;
    logic [STV_W-1:0]      starve_q, starve_d;
    logic                  pipe_hold_q, pipe_hold_d;

    wba_grant_e       gnt;
    wba_entry_t       fifo_din, fifo_head;
    logic             fifo_empty, fifo_push, fifo_pop;
    logic [CNT_W-1:0] fifo_count;
    logic             wr_w, issue_acc, retire, head_blocked;

    assign wr_w           = w_valid & w_wen & (w_rd != '0);
    assign lu_res_ready   = fifo_count < CNT_W'(FIFO_DEPTH);
    assign lu_issue_ready = (out_q < OUT_W'(MAX_OUT)) & ~busy_q[lu_issue_rd] & rst;
    assign issue_acc      = lu_issue_valid & lu_issue_ready & (lu_issue_rd != '0);
    // rd==0 results are accepted but never stored, so they never retire anything.
    assign fifo_push      = lu_res_valid & lu_res_ready & (lu_res_rd != '0) & (gnt != GNT_BYP);
    assign fifo_pop       = (gnt == GNT_FIFO);
    assign fifo_din       = {lu_res_rd, lu_res_data};
    assign retire         = (gnt == GNT_FIFO) | (gnt == GNT_BYP);
    assign head_blocked   = ~fifo_empty & (gnt != GNT_FIFO);
    assign pipe_hold      = pipe_hold_q;

    assign d_sb_stall = (d_use1 & busy_q[d_rs1] & (d_rs1 != '0)) |
                        (d_use2 & busy_q[d_rs2] & (d_rs2 != '0)) |
                        (d_wen  & busy_q[d_rd]  & (d_rd  != '0));

    wba_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (fifo_din),
        .dout_o  (fifo_head),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        gnt = GNT_NONE;
        if (!rst)                          gnt = GNT_NONE;
        else if (pipe_hold_q && !fifo_empty) gnt = GNT_FIFO;
        else if (wr_w)                     gnt = GNT_W;
        else if (!fifo_empty)              gnt = GNT_FIFO;
`ifdef WBA_BYPASS_EN
        else if (!pipe_hold_q && lu_res_valid && lu_res_rd != '0) gnt = GNT_BYP;
`endif
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        case (gnt)
            GNT_W: begin
                rf_we    = 1'b1;
                rf_waddr = w_rd;
                rf_wdata = w_wdata;
            end
            GNT_FIFO: begin
                rf_we    = 1'b1;
                rf_waddr = fifo_head.rd;
                rf_wdata = fifo_head.data;
            end
            GNT_BYP: begin
                rf_we    = 1'b1;
                rf_waddr = lu_res_rd;
                rf_wdata = lu_res_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy_d = busy_q;
        if (retire)    busy_d[rf_waddr]    = 1'b0;
        if (issue_acc) busy_d[lu_issue_rd] = 1'b1;
        out_d = out_q + OUT_W'(issue_acc) - OUT_W'(retire);
        // Hold is a one-shot: it clears on the edge where the head is finally granted.
        starve_d    = '0;
        pipe_hold_d = 1'b0;
        if (head_blocked) begin
            starve_d    = (starve_q == STARVE_LIM) ? starve_q : starve_q + 1'b1;
            pipe_hold_d = (starve_q == STARVE_LIM);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q      <= '0;
            out_q       <= '0;
            starve_q    <= '0;
            pipe_hold_q <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            out_q       <= out_d;
            starve_q    <= starve_d;
            pipe_hold_q <= pipe_hold_d;
        end
    end

endmodule
